// File: rtl/stream_buffer_pkg.sv
// Shared constants and width helpers for the stream_buffer FIFO and its counters.
package stream_buffer_pkg;

    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_buffer_beat_counter.sv
// Event counter that either wraps at all-ones or holds there, selected by SATURATE.
module beat_counter
    import stream_buffer_pkg::*;
#(
    parameter int W        = 4,
    parameter int SATURATE = CNT_MODE_WRAP
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (inc && !(SATURATE == CNT_MODE_SAT && value_q == '1)) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/stream_buffer.sv
// First-word-fall-through FIFO with valid/ready on both sides and an accepted-beat counter.
// Define STREAM_BUFFER_DROP_CNT_EN to add a saturating drop_count of refused offers.
module stream_buffer
    import stream_buffer_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = 4,
    parameter int CNT_SATURATE = CNT_MODE_WRAP
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             data_in,
    output logic                          in_ready,
    output logic [DATA_W-1:0]             data_out,
    output logic                          valid,
    input  logic                          out_ready,
    output logic [CNT_W-1:0]              counter,
    output logic [level_width(DEPTH)-1:0] level
`ifdef STREAM_BUFFER_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]              drop_count
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push;
    logic              pop;

    assign in_ready = (level_q != LVL_W'(DEPTH));
    assign valid    = (level_q != '0);
    assign push     = enable && in_ready;
    assign pop      = valid && out_ready;

    // DEPTH is a power of two, so natural pointer overflow is the mod-DEPTH wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is cleared on reset so data_out is a defined zero while empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = mem_q[rd_ptr_q];
    assign level    = level_q;

    beat_counter #(
        .W        (CNT_W),
        .SATURATE (CNT_SATURATE)
    ) u_accept_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (push),
        .value (counter)
    );

`ifdef STREAM_BUFFER_DROP_CNT_EN
    beat_counter #(
        .W        (CNT_W),
        .SATURATE (CNT_MODE_SAT)
    ) u_drop_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (enable && !in_ready),
        .value (drop_count)
    );
`endif

endmodule

// File: tb/tb_stream_buffer.sv
// Scoreboard bench for stream_buffer: a wrapping and a saturating instance share one stimulus.
module tb_stream_buffer;
    import stream_buffer_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int LVL_W  = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] data_in = '0;

    logic              in_ready, valid, in_ready_s, valid_s;
    logic [DATA_W-1:0] data_out, data_out_s;
    logic [CNT_W-1:0]  counter, counter_s;
    logic [LVL_W-1:0]  level, level_s;
`ifdef STREAM_BUFFER_DROP_CNT_EN
    logic [CNT_W-1:0]  drop_count, drop_count_s;
`endif

    stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .CNT_SATURATE(CNT_MODE_WRAP)) dut (
        .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
        .in_ready(in_ready), .data_out(data_out), .valid(valid), .out_ready(out_ready),
        .counter(counter), .level(level)
`ifdef STREAM_BUFFER_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .CNT_SATURATE(CNT_MODE_SAT)) dut_sat (
        .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
        .in_ready(in_ready_s), .data_out(data_out_s), .valid(valid_s), .out_ready(out_ready),
        .counter(counter_s), .level(level_s)
`ifdef STREAM_BUFFER_DROP_CNT_EN
        , .drop_count(drop_count_s)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic              push_pend = 1'b0;
    logic              pop_pend  = 1'b0;
    logic              drop_pend = 1'b0;
    logic [DATA_W-1:0] push_data = '0;
    int                cnt_wrap = 0;
    int                cnt_sat  = 0;
    int                drop_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Commit the transactions that the previous cycle's inputs cause at this edge.
    initial forever begin
        @(posedge clock);
        if (!reset) begin
            if (pop_pend) void'(exp_q.pop_front());
            if (push_pend) begin
                exp_q.push_back(push_data);
                cnt_wrap = (cnt_wrap + 1) % 16;
                if (cnt_sat < 15) cnt_sat++;
            end
            if (drop_pend && drop_exp < 15) drop_exp++;
        end
        push_pend = 1'b0;
        pop_pend  = 1'b0;
        drop_pend = 1'b0;
    end

    // Monitor: compare every output against the scoreboard on the falling edge.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            check("valid", valid, exp_q.size() != 0);
            check("in_ready", in_ready, exp_q.size() != DEPTH);
            check("level", level, exp_q.size());
            check("counter_wrap", counter, cnt_wrap);
            check("counter_sat", counter_s, cnt_sat);
            check("level_sat", level_s, exp_q.size());
`ifdef STREAM_BUFFER_DROP_CNT_EN
            check("drop_count", drop_count, drop_exp);
`endif
            if (exp_q.size() != 0) begin
                check("data_out", data_out, exp_q[0]);
                check("data_out_sat", data_out_s, exp_q[0]);
                if (out_ready) $display("[TB] pop  0x%02h level=%0d", data_out, level);
            end
            pop_pend = (exp_q.size() != 0) && out_ready;
        end
    end

    task automatic step(input logic en, input logic [DATA_W-1:0] din, input logic ordy);
        @(posedge clock);
        #1;
        enable    = en;
        data_in   = din;
        out_ready = ordy;
        push_pend = en && (exp_q.size() != DEPTH);
        drop_pend = en && (exp_q.size() == DEPTH);
        push_data = din;
        if (en) $display("[TB] offer 0x%02h %s", din, push_pend ? "accepted" : "refused");
    endtask

    // Asserts reset between edges and checks that outputs clear before any clock edge.
    task automatic do_reset();
        #2;
        reset     = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        push_pend = 1'b0;
        pop_pend  = 1'b0;
        drop_pend = 1'b0;
        cnt_wrap  = 0;
        cnt_sat   = 0;
        drop_exp  = 0;
        #1;
        check("rst_valid", valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_level", level, 0);
        check("rst_counter", counter, 0);
        check("rst_counter_sat", counter_s, 0);
        check("rst_data_out", data_out, 0);
`ifdef STREAM_BUFFER_DROP_CNT_EN
        check("rst_drop_count", drop_count, 0);
`endif
        $display("[TB] async reset applied");
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset then idle
        step(1'b1, 8'h99, 1'b0);
        do_reset();
        repeat (10) step(1'b0, 8'h00, 1'b1);
        @(negedge clock);
        check("idle_level", level, 0);

        // Fill with no drain, then a refused fifth offer
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clock);
        check("full_level", level, 4);
        check("full_in_ready", in_ready, 1'b0);
        check("full_head", data_out, 8'h11);
        check("full_counter", counter, 4);
`ifdef STREAM_BUFFER_DROP_CNT_EN
        check("full_drop", drop_count, 1);
`endif

        // Drain in order
        repeat (4) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clock);
        check("drained_valid", valid, 1'b0);
        check("drained_level", level, 0);

        // Full with simultaneous pop: refused this cycle, accepted the next
        step(1'b1, 8'h61, 1'b0);
        step(1'b1, 8'h62, 1'b0);
        step(1'b1, 8'h63, 1'b0);
        step(1'b1, 8'h64, 1'b0);
        step(1'b1, 8'h66, 1'b1);
        step(1'b1, 8'h77, 1'b1);
        repeat (6) step(1'b0, 8'h00, 1'b1);
        @(negedge clock);
        check("popfull_counter", counter, 9);
        check("popfull_level", level, 0);

        // Full-rate streaming across pointer wrap and counter wrap/saturate
        step(1'b0, 8'h00, 1'b0);
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h80 + i), 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clock);
        check("stream_counter_wrap", counter, 4);
        check("stream_counter_sat", counter_s, 15);
        step(1'b1, 8'hC0, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        @(negedge clock);
        check("sat_hold", counter_s, 15);
        check("wrap_next", counter, 5);

        // Reset mid-operation with three entries in flight
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clock);
        check("pre_rst_level", level, 3);
        step(1'b0, 8'h00, 1'b0);
        do_reset();
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clock);
        check("post_rst_data", data_out, 8'hA5);
        check("post_rst_level", level, 1);
        check("post_rst_counter", counter, 1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_buffer.md
Name: stream_buffer

Overview:
- Parametrised successor to the single-register enable/valid stage used in scheduler tests.
- Small synchronous FIFO with valid/ready handshake on both sides, plus an accepted-beat counter that either wraps or saturates.
- Sits between a test stimulus source and a consumer that can apply backpressure.
- Exercises multi-cycle scheduler behaviour: stalls, fill/drain, and counter wrap.

Parameters:
- DATA_W, 8, data width in bits (>=1).
- DEPTH, 4, FIFO entries; power of two, >=2.
- CNT_W, 4, width of the accepted-beat counter (>=1).
- CNT_SATURATE, 0, counter mode: 0 = wrap at 2^CNT_W-1 -> 0; 1 = hold at 2^CNT_W-1.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  upstream valid; a beat is offered when high.
- data_in  input  DATA_W  upstream data, sampled on accepted push.
- in_ready  output  1  combinational; high when FIFO not full.
- data_out  output  DATA_W  head entry (first-word-fall-through).
- valid  output  1  high when FIFO not empty.
- out_ready  input  1  downstream ready.
- counter  output  CNT_W  number of accepted pushes, wrap or saturate per CNT_SATURATE.
- level  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: counter=0, level=0, valid=0, in_ready=1, write/read pointers=0, all storage entries=0 (so data_out=0).
- Push: occurs on a posedge when enable && in_ready.
  - Writes data_in at the write pointer.
  - Write pointer advances mod DEPTH.
- Pop: occurs on a posedge when valid && out_ready.
  - Read pointer advances mod DEPTH.
- Derived outputs: in_ready = (level != DEPTH); valid = (level != 0); data_out = storage[read pointer].
- Latency: a beat pushed at edge N is on data_out with valid=1 from edge N (visible in cycle N+1) if the FIFO was empty. There is no same-cycle combinational bypass.
- Simultaneous push and pop with 0 < level < DEPTH: both happen and level is unchanged.
- Empty: pop is impossible (valid=0); a push alone sets level=1.
- Full: in_ready=0, so enable is ignored and data is not stored. A pop in the same cycle frees a slot, but in_ready stays low for that cycle; the next cycle it returns to 1.
- out_ready while empty: no effect.
- Pointer wrap: pointers roll from DEPTH-1 to 0 with no gap; level stays exact.
- Counter: +1 on every accepted push, independent of pops.
  - At all-ones with CNT_SATURATE=0: next push gives 0.
  - At all-ones with CNT_SATURATE=1: counter holds.
- Reset mid-operation: all in-flight entries are discarded, outputs return to reset values asynchronously, and no push/pop is recorded for that edge.
- data_in, enable and out_ready must be stable around posedge; no X on any output after reset.

Optional Feature:
- Macro: STREAM_BUFFER_DROP_CNT_EN.
- Defined:
  - Adds output port drop_count (CNT_W).
  - drop_count increments on each posedge where enable && !in_ready (a refused offer).
  - Always saturates at all-ones regardless of CNT_SATURATE.
  - Reset value 0.
- Undefined: port and logic are absent; no behaviour change elsewhere.

Decomposition:
- Package stream_buffer_pkg:
  - Function for pointer width, $clog2(DEPTH).
  - Function for level width, $clog2(DEPTH+1).
  - Localparam constants CNT_MODE_WRAP=0 and CNT_MODE_SAT=1.
- One sub-module, beat_counter, with params W and SATURATE and ports clock, reset, inc, value. Instantiated for counter and, when enabled, for drop_count.
- FIFO storage and pointers stay in stream_buffer.

Test Plan:
- Reset then idle:
  - Assert reset asynchronously mid-cycle -> valid=0, in_ready=1, level=0, counter=0, data_out=0 immediately.
  - enable=0 for 10 cycles -> no change.
- Fill with no drain (DEPTH=4, out_ready=0):
  - Push 0x11,0x22,0x33,0x44 -> level=4, in_ready=0, data_out=0x11, counter=4.
  - Fifth offer 0x55 -> refused; level stays 4; drop_count=1 with macro.
- Drain order:
  - From full, out_ready=1, enable=0 -> data_out sequence 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Then valid=0, level=0.
- Streaming at full rate:
  - enable=1 and out_ready=1 for 20 cycles with incrementing data -> level holds at 1, output order matches input order.
  - Pointers wrap without loss; counter=20 mod 16=4 with CNT_SATURATE=0.
- Saturate mode (CNT_SATURATE=1):
  - 20 accepted pushes -> counter=15 and holds at 15 on further pushes.
- Reset mid-operation:
  - With level=3, pulse reset -> level=0, valid=0, counter=0.
  - Subsequent push of 0xA5 -> data_out=0xA5, level=1, counter=1.
